rst_release_ctrl: RTL and testbench

Reset release controller that drives the active-high, synchronously deasserted `rst` and the `ce` enable consumed by the rest of the design. It guarantees that `rst` deasserts no earlier than MIN_DLY and no later than MAX_DLY clock edges after the reset source clears. The defaults give a 2..20 cycle window. Release is gated by a PLL/clock-lock indication, and a watchdog forces release at MAX_DLY if lock never arrives. Software can re-enter reset at any time.

---
 rtl/rst_ctrl_pkg.sv | 16 +
 rtl/sync_ff.sv | 24 ++
 rtl/rst_release_ctrl.sv | 131 +++++++++++++
 tb/tb_rst_release_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rst_ctrl_pkg.sv
// Shared types for the reset release controller: FSM state encoding and
// the sizing helper for the HOLD edge counter.
package rst_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rst_state_e;

  // Counter must be able to hold the value MAX_DLY itself.
  function automatic int cnt_width(input int max_dly);
    return (max_dly < 1) ? 1 : $clog2(max_dly + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer with asynchronous active-low clear; used
// both for reset-release sequencing and for the asynchronous lock input.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rst_release_ctrl.sv
// Reset release controller: holds rst for MIN_DLY..MAX_DLY edges after the
// reset source clears, gated by clock lock, with watchdog and software re-entry.
module rst_release_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int MIN_DLY     = 2,
  parameter int MAX_DLY     = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock_i,
  input  logic       sw_rst_req_i,
  output logic       rst,
  output logic       ce,
  output logic       timeout_o,
  output logic [1:0] state_o
);

  localparam int CW = cnt_width(MAX_DLY);
  localparam int KW = CW + 1;
  localparam logic [KW-1:0] MIN_K = KW'(MIN_DLY);
  localparam logic [KW-1:0] MAX_K = KW'(MAX_DLY);

  if (MIN_DLY < 1) begin : g_chk_min
    $error("rst_release_ctrl: MIN_DLY must be >= 1");
  end
  if (MAX_DLY < MIN_DLY) begin : g_chk_max
    $error("rst_release_ctrl: MAX_DLY must be >= MIN_DLY");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("rst_release_ctrl: SYNC_STAGES must be >= 2");
  end

  logic          w_rst_sync_n;
  logic          w_lock_s;
  rst_state_e    r_state;
  rst_state_e    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [KW-1:0] w_k;
  logic          r_rst;
  logic          w_rst_next;
  logic          r_ce;
  logic          w_ce_next;
  logic          r_timeout;
  logic          w_timeout_next;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_d    (1'b1),
    .o_q    (w_rst_sync_n)
  );

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_d    (lock_i),
    .o_q    (w_lock_s)
  );

  // r_cnt holds the number of HOLD edges already taken, so w_k is the
  // number of the edge currently being evaluated.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_timeout_next = r_timeout;
    w_k            = {1'b0, r_cnt} + KW'(1);

    case (r_state)
      HOLD: begin
        if (w_rst_sync_n) begin
          if ((w_lock_s && (w_k >= MIN_K)) || (w_k >= MAX_K)) begin
            w_state_next   = RUN;
            w_cnt_next     = '0;
            w_timeout_next = !w_lock_s;
          end else if (w_k >= MAX_K) begin
            w_cnt_next = CW'(MAX_DLY);
          end else begin
            w_cnt_next = w_k[CW-1:0];
          end
        end
      end
      RUN: begin
        w_cnt_next = '0;
        if (sw_rst_req_i || !w_lock_s) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        w_cnt_next   = '0;
        w_state_next = HOLD;
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = HOLD;
      end
    endcase

    // ce only after a full cycle in RUN, so it trails rst fall and leads rst rise.
    w_rst_next = (w_state_next == HOLD);
    w_ce_next  = (r_state == RUN) && (w_state_next == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= HOLD;
      r_cnt     <= '0;
      r_rst     <= 1'b1;
      r_ce      <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rst     <= w_rst_next;
      r_ce      <= w_ce_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign rst       = r_rst;
  assign ce        = r_ce;
  assign timeout_o = r_timeout;
  assign state_o   = r_state;

endmodule

// File: tb/tb_rst_release_ctrl.sv
// Directed bench for rst_release_ctrl with defaults (2..20 window, 2 sync stages).
module tb_rst_release_ctrl;

  logic       clk;
  logic       rst_n;
  logic       lock_i;
  logic       sw_rst_req_i;
  logic       rst;
  logic       ce;
  logic       timeout_o;
  logic [1:0] state_o;

  int n_chk  = 0;
  int n_pass = 0;
  int hold_len = 0;
  logic mon_en = 1'b0;

  rst_release_ctrl #(
    .MIN_DLY    (2),
    .MAX_DLY    (20),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lock_i      (lock_i),
    .sw_rst_req_i(sw_rst_req_i),
    .rst         (rst),
    .ce          (ce),
    .timeout_o   (timeout_o),
    .state_o     (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Invariant monitor: ce never with rst, and each rst-high stretch (after
  // rst_n is high) lies within the allowed release window.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ce_with_rst", {31'b0, ce & rst}, 32'd0);
      if (!rst_n) begin
        hold_len = 0;
      end else if (rst) begin
        hold_len++;
      end else if (hold_len > 0) begin
        chk("hold_min", {31'b0, hold_len >= 2}, 32'd1);
        chk("hold_max", {31'b0, hold_len <= 22}, 32'd1);
        hold_len = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b1; lock_i = 1'b1; sw_rst_req_i = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    mon_en = 1'b1;
    chk("reset_rst", rst, 1);
    chk("reset_ce", ce, 0);
    chk("reset_timeout", timeout_o, 0);
    chk("reset_state", state_o, 0);

    // lock high throughout: release at HOLD edge 2, ce one edge later
    rst_n = 1'b1;
    tick(3);
    chk("c1_hold_e1_rst", rst, 1);
    tick(1);
    chk("c1_rel_rst", rst, 0);
    chk("c1_rel_ce", ce, 0);
    chk("c1_rel_state", state_o, 1);
    tick(1);
    chk("c1_ce_up", ce, 1);
    chk("c1_timeout", timeout_o, 0);

    // software re-entry from RUN
    sw_rst_req_i = 1'b1;
    tick(1);
    sw_rst_req_i = 1'b0;
    chk("c4_drain_state", state_o, 2);
    chk("c4_drain_ce", ce, 0);
    chk("c4_drain_rst", rst, 0);
    tick(1);
    chk("c4_hold_rst", rst, 1);
    chk("c4_hold_state", state_o, 0);
    tick(1);
    chk("c4_hold_e1_rst", rst, 1);
    tick(1);
    chk("c4_rel_rst", rst, 0);
    chk("c4_rel_ce", ce, 0);
    tick(1);
    chk("c4_ce_up", ce, 1);

    // late lock: lock_s first high at HOLD edge 9
    lock_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("c2_async_rst", rst, 1);
    chk("c2_async_ce", ce, 0);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    lock_i = 1'b1;
    tick(2);
    chk("c2_e8_rst", rst, 1);
    tick(1);
    chk("c2_e9_rst", rst, 0);
    chk("c2_e9_timeout", timeout_o, 0);
    tick(1);
    chk("c2_ce_up", ce, 1);

    // no lock: watchdog release at HOLD edge 20
    lock_i = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(21);
    chk("c3_e19_rst", rst, 1);
    chk("c3_e19_timeout", timeout_o, 0);
    tick(1);
    chk("c3_e20_rst", rst, 0);
    chk("c3_e20_timeout", timeout_o, 1);
    chk("c3_e20_state", state_o, 1);
    lock_i = 1'b1;
    sw_rst_req_i = 1'b1;
    tick(1);
    sw_rst_req_i = 1'b0;
    chk("c3_drain_state", state_o, 2);
    chk("c3_drain_ce", ce, 0);
    tick(1);
    chk("c3_hold_rst", rst, 1);
    chk("c3_sticky_timeout", timeout_o, 1);
    tick(1);
    chk("c3_hold_e1_rst", rst, 1);
    tick(1);
    chk("c3_rel2_rst", rst, 0);
    chk("c3_rel2_timeout", timeout_o, 0);
    tick(1);
    chk("c3_ce_up", ce, 1);

    // lock drop together with sw request: one DRAIN, then forced release
    lock_i = 1'b0;
    sw_rst_req_i = 1'b1;
    tick(1);
    sw_rst_req_i = 1'b0;
    chk("c6_drain_state", state_o, 2);
    tick(1);
    chk("c6_hold_state", state_o, 0);
    chk("c6_hold_rst", rst, 1);
    tick(19);
    chk("c6_e19_rst", rst, 1);
    tick(1);
    chk("c6_e20_rst", rst, 0);
    chk("c6_e20_timeout", timeout_o, 1);

    // lock still low: drain again, then rst_n pulse at HOLD edge 5
    tick(1);
    chk("c5_drain_state", state_o, 2);
    tick(1);
    chk("c5_hold_rst", rst, 1);
    tick(5);
    chk("c5_e5_rst", rst, 1);
    chk("c5_e5_timeout", timeout_o, 1);
    lock_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("c5_async_rst", rst, 1);
    chk("c5_async_ce", ce, 0);
    chk("c5_async_timeout", timeout_o, 0);
    chk("c5_async_state", state_o, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("c5_new_e1_rst", rst, 1);
    tick(1);
    chk("c5_new_e2_rst", rst, 0);
    chk("c5_new_e2_state", state_o, 1);
    tick(1);
    chk("c5_ce_up", ce, 1);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
